// File: rtl/memory_unit.sv
// Main memory stage of the common-bus datapath: a single-port word array with a
// programmable wait-state count, one request in flight, and a READY pulse per access.
module memory_unit #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int WAIT   = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic [DATA_W-1:0] MEM_OUT,
    output logic              BUSY,
    output logic              READY,
    output logic              ERR
);

    // state  | meaning
    // IDLE   | waiting for a single READ or WRITE request
    // ACCESS | request latched, counting down wait states; access happens at cnt==0
    // DONE   | access complete, READY asserted for this one cycle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                op_write_q;
    logic                err_q;
    logic                accept;
    logic                access_fire;

    logic [DATA_W-1:0]   mem [0:(2**ADDR_W)-1];

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        access_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (READ ^ WRITE) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    access_fire = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign BUSY  = (state_q == ACCESS);
    assign READY = (state_q == DONE);
    assign ERR   = err_q;

    // All state moves on the falling edge, in step with the datapath registers.
    always_ff @(negedge CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            data_q     <= '0;
            op_write_q <= 1'b0;
            err_q      <= 1'b0;
            MEM_OUT    <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == IDLE) && READ && WRITE;
            if (accept) begin
                addr_q     <= ADDR;
                op_write_q <= WRITE;
                cnt_q      <= WAIT_CNT;
                if (WRITE) begin
                    data_q <= WR_DATA;
                end
            end else if (state_q == ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (access_fire && !op_write_q) begin
                MEM_OUT <= mem[addr_q];
            end
        end
    end

    // The array itself is never cleared; reset only blocks a pending write.
    always_ff @(negedge CLK) begin
        if (!reset && access_fire && op_write_q) begin
            mem[addr_q] <= data_q;
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: one instance with WAIT=2 and one with WAIT=0,
// sharing clock and reset; outputs are sampled 1ns after each falling edge.
module tb_memory_unit;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;

    logic        rd2 = 1'b0, wr2 = 1'b0;
    logic [11:0] addr2 = '0;
    logic [15:0] wdat2 = '0;
    logic [15:0] out2;
    logic        busy2, ready2, err2;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [11:0] addr0 = '0;
    logic [15:0] wdat0 = '0;
    logic [15:0] out0;
    logic        busy0, ready0, err0;

    int vectors = 0;
    int miscompares = 0;

    memory_unit #(.ADDR_W(12), .DATA_W(16), .WAIT(2)) dut2 (
        .CLK(CLK), .reset(reset), .READ(rd2), .WRITE(wr2), .ADDR(addr2), .WR_DATA(wdat2),
        .MEM_OUT(out2), .BUSY(busy2), .READY(ready2), .ERR(err2)
    );

    memory_unit #(.ADDR_W(12), .DATA_W(16), .WAIT(0)) dut0 (
        .CLK(CLK), .reset(reset), .READ(rd0), .WRITE(wr0), .ADDR(addr0), .WR_DATA(wdat0),
        .MEM_OUT(out0), .BUSY(busy0), .READY(ready0), .ERR(err0)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Issues one request to the chosen instance and measures it. ready_at is the number
    // of edges after the accept edge at which READY was seen (-1 on timeout); ready_after
    // is READY one edge later.
    task automatic access(input bit sel0, input bit is_write, input logic [11:0] a,
                          input logic [15:0] d, output int ready_at, output int busy_n,
                          output logic ready_after);
        int n;
        if (sel0) begin
            rd0 = !is_write; wr0 = is_write; addr0 = a; wdat0 = d;
        end else begin
            rd2 = !is_write; wr2 = is_write; addr2 = a; wdat2 = d;
        end
        tick();
        rd0 = 1'b0; wr0 = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
        n = 0;
        busy_n = 0;
        ready_at = -1;
        while (n < 20) begin
            if (sel0 ? busy0 : busy2) busy_n++;
            if (sel0 ? ready0 : ready2) begin
                ready_at = n;
                break;
            end
            tick();
            n++;
        end
        tick();
        ready_after = sel0 ? ready0 : ready2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if ({out2, busy2, ready2, err2} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_w2: got out=%h busy=%b ready=%b err=%b, want all 0", out2, busy2, ready2, err2);
        end
        vectors++;
        if ({out0, busy0, ready0, err0} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_w0: got out=%h busy=%b ready=%b err=%b, want all 0", out0, busy0, ready0, err0);
        end
    endtask

    task automatic test_write_read();
        int ra, bn;
        logic rf;
        access(1'b0, 1'b1, 12'h005, 16'hBEEF, ra, bn, rf);
        vectors++;
        if (ra !== 3 || bn !== 3 || rf !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_latency: got ready_at=%0d busy=%0d ready_after=%b, want 3 3 0", ra, bn, rf);
        end
        vectors++;
        if (out2 !== 16'h0000) begin
            miscompares++;
            $display("FAIL wr_no_memout: got %h, want 0000", out2);
        end
        access(1'b0, 1'b0, 12'h005, 16'h0000, ra, bn, rf);
        vectors++;
        if (ra !== 3 || bn !== 3 || rf !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_latency: got ready_at=%0d busy=%0d ready_after=%b, want 3 3 0", ra, bn, rf);
        end
        vectors++;
        if (out2 !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL rd_data: got %h, want beef", out2);
        end
    endtask

    task automatic test_error();
        int ra, bn;
        logic rf;
        rd2 = 1'b1; wr2 = 1'b1; addr2 = 12'h005; wdat2 = 16'h0BAD;
        tick();
        rd2 = 1'b0; wr2 = 1'b0;
        vectors++;
        if (err2 !== 1'b1 || busy2 !== 1'b0 || ready2 !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse: got err=%b busy=%b ready=%b, want 1 0 0", err2, busy2, ready2);
        end
        tick();
        vectors++;
        if (err2 !== 1'b0 || busy2 !== 1'b0 || out2 !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL err_after: got err=%b busy=%b out=%h, want 0 0 beef", err2, busy2, out2);
        end
        access(1'b0, 1'b0, 12'h005, 16'h0000, ra, bn, rf);
        vectors++;
        if (out2 !== 16'hBEEF || ra !== 3) begin
            miscompares++;
            $display("FAIL err_mem_kept: got out=%h ready_at=%0d, want beef 3", out2, ra);
        end
    endtask

    task automatic test_ignore_during_access();
        int ra, bn, nready;
        logic rf;
        access(1'b0, 1'b1, 12'h006, 16'h0066, ra, bn, rf);
        wr2 = 1'b1; addr2 = 12'h007; wdat2 = 16'hCAFE;
        tick();
        addr2 = 12'h006; wdat2 = 16'hDEAD;
        tick();
        wr2 = 1'b0;
        nready = 0;
        for (int i = 0; i < 10; i++) begin
            if (ready2) nready++;
            tick();
        end
        vectors++;
        if (nready !== 1) begin
            miscompares++;
            $display("FAIL ignore_ready_count: got %0d READY pulses, want 1", nready);
        end
        access(1'b0, 1'b0, 12'h007, 16'h0000, ra, bn, rf);
        vectors++;
        if (out2 !== 16'hCAFE) begin
            miscompares++;
            $display("FAIL ignore_orig_addr: got %h, want cafe", out2);
        end
        access(1'b0, 1'b0, 12'h006, 16'h0000, ra, bn, rf);
        vectors++;
        if (out2 !== 16'h0066) begin
            miscompares++;
            $display("FAIL ignore_other_addr: got %h, want 0066", out2);
        end
    endtask

    task automatic test_reset_mid_write();
        int ra, bn, nready;
        logic rf;
        access(1'b0, 1'b1, 12'hFFF, 16'h0777, ra, bn, rf);
        wr2 = 1'b1; addr2 = 12'hFFF; wdat2 = 16'h1234;
        tick();
        wr2 = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (busy2 !== 1'b0 || ready2 !== 1'b0 || out2 !== 16'h0000) begin
            miscompares++;
            $display("FAIL midreset_state: got busy=%b ready=%b out=%h, want 0 0 0000", busy2, ready2, out2);
        end
        nready = 0;
        for (int i = 0; i < 6; i++) begin
            if (ready2) nready++;
            tick();
        end
        vectors++;
        if (nready !== 0) begin
            miscompares++;
            $display("FAIL midreset_ready: got %0d READY pulses, want 0", nready);
        end
        access(1'b0, 1'b0, 12'hFFF, 16'h0000, ra, bn, rf);
        vectors++;
        if (out2 !== 16'h0777) begin
            miscompares++;
            $display("FAIL midreset_old_data: got %h, want 0777", out2);
        end
    endtask

    task automatic test_wait0_back_to_back();
        int ra, bn;
        logic rf;
        access(1'b1, 1'b1, 12'h000, 16'hA5A5, ra, bn, rf);
        vectors++;
        if (ra !== 1 || bn !== 1 || rf !== 1'b0) begin
            miscompares++;
            $display("FAIL w0_wr0_latency: got ready_at=%0d busy=%0d ready_after=%b, want 1 1 0", ra, bn, rf);
        end
        access(1'b1, 1'b1, 12'hFFF, 16'h5A5A, ra, bn, rf);
        vectors++;
        if (ra !== 1 || out0 !== 16'h0000) begin
            miscompares++;
            $display("FAIL w0_wrfff: got ready_at=%0d out=%h, want 1 0000", ra, out0);
        end
        access(1'b1, 1'b0, 12'h000, 16'h0000, ra, bn, rf);
        vectors++;
        if (ra !== 1 || out0 !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL w0_rd0: got ready_at=%0d out=%h, want 1 a5a5", ra, out0);
        end
        access(1'b1, 1'b0, 12'hFFF, 16'h0000, ra, bn, rf);
        vectors++;
        if (ra !== 1 || bn !== 1 || out0 !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL w0_rdfff: got ready_at=%0d busy=%0d out=%h, want 1 1 5a5a", ra, bn, out0);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_write_read();
        test_error();
        test_ignore_during_access();
        test_reset_mid_write();
        test_wait0_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
